// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_t  - arbiter FSM states
//   owner_t  - which cache owns the block fill in flight
//   WORD_BYTES, BLK_OFFSET_MASK - word size and default in-block byte offset mask
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int WORD_BYTES    = 2;
  localparam int BLK_WORDS_DEF = 8;

  // Byte-offset mask of a block holding blk_words 16-bit words.
  function automatic int offset_mask(input int blk_words);
    return blk_words * WORD_BYTES - 1;
  endfunction

  localparam int BLK_OFFSET_MASK = BLK_WORDS_DEF * WORD_BYTES - 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response bundle between the caches, the
// arbiter and memory4c.
//   cache side : i_miss/i_addr, d_miss/d_addr, wr_req/wr_addr/wr_data in;
//                fill_data/fill_addr, i_fill_we/d_fill_we, i_done/d_done,
//                wr_ack, stall out
//   memory side: mem_rdata/mem_vld in; mem_en/mem_wr/mem_addr/mem_wdata out
//   slave  modport: the arbiter
//   master modport: whatever drives the requests and models the memory
interface mem_port_arbiter_if #(
  parameter int AW = 16
);

  logic          i_miss;
  logic [AW-1:0] i_addr;
  logic          d_miss;
  logic [AW-1:0] d_addr;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [15:0]   mem_rdata;
  logic          mem_vld;

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   fill_data;
  logic [AW-1:0] fill_addr;
  logic          i_fill_we;
  logic          d_fill_we;
  logic          i_done;
  logic          d_done;
  logic          wr_ack;
  logic          stall;

  modport slave (
    input  i_miss, i_addr, d_miss, d_addr, wr_req, wr_addr, wr_data,
           mem_rdata, mem_vld,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_addr,
           i_fill_we, d_fill_we, i_done, d_done, wr_ack, stall
  );

  modport master (
    output i_miss, i_addr, d_miss, d_addr, wr_req, wr_addr, wr_data,
           mem_rdata, mem_vld,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_addr,
           i_fill_we, d_fill_we, i_done, d_done, wr_ack, stall
  );

endinterface

// File: rtl/mem_port_arbiter_fill_seq.sv
// mem_fill_seq: block-fill address sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   i_load          : latch a new block base from i_addr, clear counters
//   i_addr          : miss byte address (low offset bits are discarded)
//   i_issue_adv     : a read was issued this cycle
//   i_ret_adv       : a read returned this cycle
//   o_issue_addr    : address of the next read to issue
//   o_ret_addr      : address of the word returning now
//   o_issue_last    : next issue is the last word of the block
//   o_ret_last      : next return is the last word of the block
module mem_fill_seq
  import mem_arb_pkg::*;
#(
  parameter int BLK_WORDS = 8,
  parameter int AW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic          i_issue_adv,
  input  logic          i_ret_adv,
  output logic [AW-1:0] o_issue_addr,
  output logic [AW-1:0] o_ret_addr,
  output logic          o_issue_last,
  output logic          o_ret_last
);

  localparam int            CNT_W    = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [AW-1:0] OFF_MASK = AW'(offset_mask(BLK_WORDS));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_WORDS - 1);

  logic [AW-1:0]    r_base;
  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] r_rcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
      r_icnt <= '0;
      r_rcnt <= '0;
    end else if (i_load) begin
      r_base <= i_addr & ~OFF_MASK;
      r_icnt <= '0;
      r_rcnt <= '0;
    end else begin
      // Counters wrap to zero after the last word, ready for the next block.
      if (i_issue_adv) r_icnt <= r_icnt + CNT_W'(1);
      if (i_ret_adv)   r_rcnt <= r_rcnt + CNT_W'(1);
    end
  end

  // The base is block aligned, so the word offset never carries out of it.
  assign o_issue_addr = r_base + AW'(r_icnt) * AW'(WORD_BYTES);
  assign o_ret_addr   = r_base + AW'(r_rcnt) * AW'(WORD_BYTES);
  assign o_issue_last = (r_icnt == CNT_LAST);
  assign o_ret_last   = (r_rcnt == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sole owner of the memory4c port, shared by I-cache fills,
// D-cache fills and D-cache write-through stores.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (cache requests/responses and the
//              memory4c enable/address/data/valid signals)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrate; stores go straight to memory, fills are granted
//   ISSUE | one block read per cycle, BLK_WORDS reads in total
//   DRAIN | all reads issued, waiting for the remaining returns
//   DONE  | one-cycle done pulse to the fill owner, flip rr preference
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8,
  parameter int AW        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  // Fill completion is driven by returns, so any latency of at least one
  // cycle works; a zero-latency memory would return during the last issue.
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  state_t r_state;
  owner_t r_owner;
  owner_t r_rr_pref;

  logic          w_idle;
  logic          w_store;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_grant;
  logic [AW-1:0] w_req_addr;
  logic          w_issue;
  logic          w_ret;
  logic [AW-1:0] w_issue_addr;
  logic [AW-1:0] w_ret_addr;
  logic          w_issue_last;
  logic          w_ret_last;

  // Every output is forced low while reset is asserted.
  assign w_idle    = ~rst & (r_state == IDLE);
  assign w_store   = w_idle & bus.wr_req;
  assign w_grant_i = w_idle & ~bus.wr_req & bus.i_miss &
                     (~bus.d_miss | (r_rr_pref == OWN_I));
  assign w_grant_d = w_idle & ~bus.wr_req & bus.d_miss &
                     (~bus.i_miss | (r_rr_pref == OWN_D));
  assign w_grant    = w_grant_i | w_grant_d;
  assign w_req_addr = w_grant_i ? bus.i_addr : bus.d_addr;

  assign w_issue = ~rst & (r_state == ISSUE);
  assign w_ret   = ~rst & bus.mem_vld & ((r_state == ISSUE) | (r_state == DRAIN));

  mem_fill_seq #(
    .BLK_WORDS (BLK_WORDS),
    .AW        (AW)
  ) u_fill_seq (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_grant),
    .i_addr       (w_req_addr),
    .i_issue_adv  (w_issue),
    .i_ret_adv    (w_ret),
    .o_issue_addr (w_issue_addr),
    .o_ret_addr   (w_ret_addr),
    .o_issue_last (w_issue_last),
    .o_ret_last   (w_ret_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= OWN_NONE;
      r_rr_pref <= OWN_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_grant_i ? OWN_I : OWN_D;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_ret && w_ret_last) r_state <= DONE;
        end
        DONE: begin
          r_rr_pref <= (r_owner == OWN_I) ? OWN_D : OWN_I;
          r_owner   <= OWN_NONE;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = w_store | w_issue;
  assign bus.mem_wr    = w_store;
  assign bus.mem_addr  = w_store ? bus.wr_addr : (w_issue ? w_issue_addr : '0);
  assign bus.mem_wdata = w_store ? bus.wr_data : 16'h0000;
  assign bus.wr_ack    = w_store;

  assign bus.fill_data = w_ret ? bus.mem_rdata : 16'h0000;
  assign bus.fill_addr = w_ret ? w_ret_addr : '0;
  assign bus.i_fill_we = w_ret & (r_owner == OWN_I);
  assign bus.d_fill_we = w_ret & (r_owner == OWN_D);

  assign bus.i_done = ~rst & (r_state == DONE) & (r_owner == OWN_I);
  assign bus.d_done = ~rst & (r_state == DONE) & (r_owner == OWN_D);

  assign bus.stall = ~rst & (bus.i_miss | bus.d_miss | (bus.wr_req & ~w_store));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a
// timeline model of the arbiter (fill phases counted from the grant cycle)
// and a simple pipelined memory with fixed latency.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 16;
  localparam int LAT = 4;
  localparam int BW  = 8;
  localparam int DONE_K = BW + LAT + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(
    .MEM_LAT   (LAT),
    .BLK_WORDS (BW),
    .AW        (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] img [0:65535];
  typedef struct { int due; logic [15:0] addr; } rd_t;
  rd_t rdq[$];

  // reference model: idle, or busy with a fill granted at cycle m_g
  bit          m_busy = 1'b0;
  int          m_g    = 0;
  int          m_own  = 0;  // 1 = I, 2 = D
  int          m_pref = 1;
  int          m_nret = 0;
  logic [15:0] m_base = '0;

  bit i_wait = 0, d_wait = 0;
  int i_we_cnt = 0, d_we_cnt = 0, ack_cnt = 0, idone_cnt = 0, ddone_cnt = 0;
  int idone_cyc = 0, ddone_cyc = 0, ack_cyc = 0;
  int done_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic eval();
    logic e_en, e_wr, e_ack, e_iwe, e_dwe, e_idone, e_ddone, e_stall;
    logic [15:0] e_addr, e_wdata, e_faddr, e_fdata;
    int k;
    {e_en, e_wr, e_ack, e_iwe, e_dwe, e_idone, e_ddone, e_stall} = '0;
    e_addr = '0; e_wdata = '0; e_faddr = '0; e_fdata = '0;
    k = 0;
    if (rst) begin
      // everything stays low
    end else if (!m_busy) begin
      e_stall = bus.i_miss | bus.d_miss;
      if (bus.wr_req) begin
        e_en = 1; e_wr = 1; e_ack = 1;
        e_addr = bus.wr_addr; e_wdata = bus.wr_data;
      end
    end else begin
      k = cyc - m_g;
      e_stall = bus.i_miss | bus.d_miss | bus.wr_req;
      if (k >= 1 && k <= BW) begin
        e_en = 1;
        e_addr = m_base + 16'(2 * (k - 1));
      end
      if (bus.mem_vld && k <= BW + LAT) begin
        if (m_own == 1) e_iwe = 1; else e_dwe = 1;
        e_faddr = m_base + 16'(2 * m_nret);
        e_fdata = img[e_faddr];
      end
      if (k == DONE_K) begin
        if (m_own == 1) e_idone = 1; else e_ddone = 1;
      end
    end

    chk("mem_en", bus.mem_en, e_en);
    chk("mem_wr", bus.mem_wr, e_wr);
    if (e_en || rst) chk("mem_addr", bus.mem_addr, e_addr);
    if (e_wr || rst) chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("wr_ack", bus.wr_ack, e_ack);
    chk("i_fill_we", bus.i_fill_we, e_iwe);
    chk("d_fill_we", bus.d_fill_we, e_dwe);
    if (e_iwe || e_dwe || rst) begin
      chk("fill_addr", bus.fill_addr, e_faddr);
      chk("fill_data", bus.fill_data, e_fdata);
    end
    chk("i_done", bus.i_done, e_idone);
    chk("d_done", bus.d_done, e_ddone);
    chk("stall", bus.stall, e_stall);

    if (rst) begin
      m_busy = 0;
      m_pref = 1;
    end else if (!m_busy) begin
      if (!bus.wr_req && (bus.i_miss || bus.d_miss)) begin
        m_own  = (bus.i_miss && (!bus.d_miss || m_pref == 1)) ? 1 : 2;
        m_base = (m_own == 1 ? bus.i_addr : bus.d_addr) & ~16'(BLK_OFFSET_MASK);
        m_busy = 1;
        m_g    = cyc;
        m_nret = 0;
      end
    end else begin
      if (e_iwe || e_dwe) m_nret++;
      if (k == DONE_K) begin
        chk("ret_count", m_nret, BW);
        m_busy = 0;
        m_pref = 3 - m_own;
      end
    end

    // memory4c: acts on what the DUT actually drove; shares reset
    if (rst) rdq.delete();
    else if (bus.mem_en && bus.mem_wr) img[bus.mem_addr] = bus.mem_wdata;
    else if (bus.mem_en) rdq.push_back('{cyc + LAT, bus.mem_addr});
  endtask

  task automatic step();
    bit saw_i, saw_d, saw_w;
    @(negedge clk);
    eval();
    saw_i = bus.i_done; saw_d = bus.d_done; saw_w = bus.wr_ack;
    if (saw_i) begin idone_cnt++; idone_cyc = cyc; done_q.push_back(1); end
    if (saw_d) begin ddone_cnt++; ddone_cyc = cyc; done_q.push_back(2); end
    if (saw_w) begin ack_cnt++; ack_cyc = cyc; end
    if (bus.i_fill_we) i_we_cnt++;
    if (bus.d_fill_we) d_we_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (saw_i) begin bus.i_miss = 0; i_wait = 0; end
    if (saw_d) begin bus.d_miss = 0; d_wait = 0; end
    if (saw_w) bus.wr_req = 0;
    bus.mem_vld = 0;
    bus.mem_rdata = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      bus.mem_vld = 1;
      bus.mem_rdata = img[rdq[0].addr];
      void'(rdq.pop_front());
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((m_busy || bus.i_miss || bus.d_miss || bus.wr_req) && n < max_cyc) begin
      step();
      n++;
    end
    chk("idle_timeout", (n < max_cyc), 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    bus.i_miss = 0; bus.d_miss = 0; bus.wr_req = 0;
    i_wait = 0; d_wait = 0;
    repeat (n) step();
    rst = 0;
  endtask

  initial begin
    int c0, i0, d0, a0, dd0, n;
    for (int a = 0; a < 65536; a++) img[a] = 16'((a * 40503) >> 3) ^ 16'h3C5A;
    rst = 1;
    bus.i_miss = 0; bus.i_addr = '0; bus.d_miss = 0; bus.d_addr = '0;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mem_vld = 0; bus.mem_rdata = '0;
    @(posedge clk);
    #1;
    do_reset(3);
    step();

    // lone I fill
    bus.i_miss = 1; bus.i_addr = 16'h0136; i_wait = 1;
    c0 = cyc; i0 = i_we_cnt;
    wait_idle(40);
    chk("i_done_lat", idone_cyc - c0, 13);
    chk("i_we_lone", i_we_cnt - i0, BW);

    // store in IDLE, then back-to-back stores
    a0 = ack_cnt;
    bus.wr_req = 1; bus.wr_addr = 16'h2000; bus.wr_data = 16'hBEEF;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.wr_req = 1; bus.wr_addr = 16'(16'h2002 + 2 * i); bus.wr_data = 16'($urandom);
      step();
    end
    chk("b2b_acks", ack_cnt - a0, 4);

    // store held off during a D fill
    i0 = i_we_cnt; d0 = d_we_cnt;
    bus.d_miss = 1; bus.d_addr = 16'h4008; d_wait = 1;
    step();
    bus.wr_req = 1; bus.wr_addr = 16'h4000; bus.wr_data = 16'h1234;
    wait_idle(60);
    chk("d_we_cnt", d_we_cnt - d0, BW);
    chk("i_we_none", i_we_cnt - i0, 0);
    chk("ack_after_ddone", ack_cyc - ddone_cyc, 1);

    // simultaneous I and D after reset: I first
    do_reset(1);
    step();
    done_q.delete();
    bus.i_miss = 1; bus.i_addr = 16'h0010; i_wait = 1;
    bus.d_miss = 1; bus.d_addr = 16'h8000; d_wait = 1;
    wait_idle(80);
    chk("order_n", done_q.size(), 2);
    chk("order_first", (done_q.size() > 0) ? done_q[0] : 0, 1);
    chk("order_second", (done_q.size() > 1) ? done_q[1] : 0, 2);
    bus.i_miss = 1; bus.i_addr = 16'h0020; i_wait = 1;
    bus.d_miss = 1; bus.d_addr = 16'h8020; d_wait = 1;
    wait_idle(80);
    bus.i_miss = 1; bus.i_addr = 16'h0030; i_wait = 1;
    bus.d_miss = 1; bus.d_addr = 16'h8030; d_wait = 1;
    bus.wr_req = 1; bus.wr_addr = 16'h9000; bus.wr_data = 16'hCAFE;
    a0 = ack_cnt;
    step();
    chk("store_wins", ack_cnt - a0, 1);
    wait_idle(80);

    // reset at the 3rd return of a fill
    d0 = d_we_cnt;
    bus.d_miss = 1; bus.d_addr = 16'h1230; d_wait = 1;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (bus.mem_vld && (d_we_cnt - d0) == 2) break;
    end
    chk("third_ret_seen", (n < 40), 1);
    dd0 = ddone_cnt;
    do_reset(1);
    repeat (16) step();
    chk("no_done_after_rst", ddone_cnt - dd0, 0);
    d0 = d_we_cnt;
    bus.d_miss = 1; bus.d_addr = 16'h1230; d_wait = 1;
    wait_idle(40);
    chk("refill_we", d_we_cnt - d0, BW);

    // stray mem_vld in IDLE
    i0 = i_we_cnt; d0 = d_we_cnt;
    bus.mem_vld = 1; bus.mem_rdata = 16'h5A5A;
    step();
    chk("stray_we", (i_we_cnt - i0) + (d_we_cnt - d0), 0);
    bus.i_miss = 1; bus.i_addr = 16'h7FF2; i_wait = 1;
    wait_idle(40);

    // random traffic
    for (int r = 0; r < 2500; r++) begin
      if (!i_wait && $urandom_range(7) == 0) begin
        bus.i_miss = 1; bus.i_addr = 16'($urandom); i_wait = 1;
      end
      if (!d_wait && $urandom_range(7) == 0) begin
        bus.d_miss = 1; bus.d_addr = 16'($urandom); d_wait = 1;
      end
      if (!bus.wr_req && $urandom_range(3) == 0) begin
        bus.wr_req = 1; bus.wr_addr = 16'($urandom) & 16'hFFFE; bus.wr_data = 16'($urandom);
      end
      if (m_busy && m_own == 1 && bus.i_miss && $urandom_range(15) == 0) bus.i_miss = 0;
      if (m_busy && m_own == 2 && bus.d_miss && $urandom_range(15) == 0) bus.d_miss = 0;
      if (!m_busy && rdq.size() == 0 && !bus.mem_vld && $urandom_range(19) == 0) begin
        bus.mem_vld = 1; bus.mem_rdata = 16'($urandom);
      end
      if ($urandom_range(299) == 0) begin
        do_reset(1);
      end else begin
        step();
      end
    end
    wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
